// File: rtl/icache_pair_resp_pkg.sv
// Shared definitions for the IF-side instruction cache responder: state encoding,
// default geometry and the response bus packing used by the IF stage.
package icache_pair_resp_pkg;

    localparam int unsigned IDX_W_DEFAULT = 6;
    localparam int unsigned RESP_W        = 66;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMiss,
        StResp,
        StDrain
    } state_e;

    // Field order matches the IF-side bus {inst2_en, inst2, inst1_en, inst1}
    typedef struct packed {
        logic        inst2_en;
        logic [31:0] inst2;
        logic        inst1_en;
        logic [31:0] inst1;
    } resp_t;

    function automatic resp_t pack_resp(input logic inst2_en, input logic [31:0] inst2,
                                        input logic inst1_en, input logic [31:0] inst1);
        resp_t r;
        r.inst2_en = inst2_en;
        r.inst2    = inst2;
        r.inst1_en = inst1_en;
        r.inst1    = inst1;
        return r;
    endfunction

endpackage

// File: rtl/icache_word_array.sv
// Direct-mapped word store: valid/tag/data per entry, two combinational read ports,
// one prioritised write port and a flash invalidate.
module icache_word_array
    import icache_pair_resp_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEFAULT,
    localparam int unsigned TAG_W = 32 - IDX_W - 2,
    localparam int unsigned ENTRIES = 1 << IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx1,
    input  logic [IDX_W-1:0] rd_idx2,
    output logic             rd_valid1,
    output logic             rd_valid2,
    output logic [TAG_W-1:0] rd_tag1,
    output logic [TAG_W-1:0] rd_tag2,
    output logic [31:0]      rd_data1,
    output logic [31:0]      rd_data2,
    input  logic             inv_all,
    input  logic             refill_en,
    input  logic [IDX_W-1:0] refill_idx,
    input  logic [TAG_W-1:0] refill_tag,
    input  logic [31:0]      refill_data,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [31:0]      fill_data
);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [31:0]        data_q [ENTRIES];

    logic             we;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [31:0]      w_data;

    // Invalidate beats refill, refill beats the IF-side fill
    always_comb begin
        we     = !inv_all && (refill_en || fill_en);
        w_idx  = refill_en ? refill_idx  : fill_idx;
        w_tag  = refill_en ? refill_tag  : fill_tag;
        w_data = refill_en ? refill_data : fill_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (inv_all) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[w_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[w_idx]  <= w_tag;
            data_q[w_idx] <= w_data;
        end
    end

    assign rd_valid1 = valid_q[rd_idx1];
    assign rd_valid2 = valid_q[rd_idx2];
    assign rd_tag1   = tag_q[rd_idx1];
    assign rd_tag2   = tag_q[rd_idx2];
    assign rd_data1  = data_q[rd_idx1];
    assign rd_data2  = data_q[rd_idx2];

endmodule

// File: rtl/icache_pair_resp.sv
// Dual-lane fetch responder: looks up pc1/pc2 in the word array, refills lane1 misses
// from instruction memory and returns a registered response to the IF stage.
module icache_pair_resp
    import icache_pair_resp_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_pc1_i,
    input  logic [31:0] req_pc2_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_inst1_o,
    output logic        resp_inst1_en_o,
    output logic [31:0] resp_inst2_o,
    output logic        resp_inst2_en_o,
    input  logic        cancel_i,
    input  logic        inv_all_i,
    input  logic        wr_en_i,
    input  logic [31:0] wr_pc_i,
    input  logic [31:0] wr_inst_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    state_e      state;
    logic [31:0] pc1_q, pc2_q;
    resp_t       resp_q;
    logic        resp_valid_q;
    logic        mem_req_q;
    logic [31:0] mem_addr_q;

    logic             valid1, valid2;
    logic [TAG_W-1:0] tag1, tag2;
    logic [31:0]      data1, data2;
    logic             hit1, pair_ok, accept, refill_en, fill_en;

    icache_word_array #(.IDX_W(IDX_W)) u_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx1     (pc1_q[IDX_W+1:2]),
        .rd_idx2     (pc2_q[IDX_W+1:2]),
        .rd_valid1   (valid1),
        .rd_valid2   (valid2),
        .rd_tag1     (tag1),
        .rd_tag2     (tag2),
        .rd_data1    (data1),
        .rd_data2    (data2),
        .inv_all     (inv_all_i),
        .refill_en   (refill_en),
        .refill_idx  (pc1_q[IDX_W+1:2]),
        .refill_tag  (pc1_q[31:IDX_W+2]),
        .refill_data (mem_rdata_i),
        .fill_en     (fill_en),
        .fill_idx    (wr_pc_i[IDX_W+1:2]),
        .fill_tag    (wr_pc_i[31:IDX_W+2]),
        .fill_data   (wr_inst_i)
    );

    assign hit1    = valid1 && (tag1 == pc1_q[31:IDX_W+2]);
    // Lane2 only counts when it is the sequential, aligned successor of lane1
    assign pair_ok = valid2 && (tag2 == pc2_q[31:IDX_W+2]) &&
                     (pc2_q == pc1_q + 32'd4) && (pc2_q[1:0] == 2'b00);

    assign req_ready_o = (state == StIdle) || ((state == StResp) && resp_ready_i);
    assign accept      = req_valid_i && req_ready_o && !cancel_i;
    assign refill_en   = mem_ack_i && ((state == StMiss) || (state == StDrain));
    assign fill_en     = wr_en_i && (wr_pc_i[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            pc1_q        <= '0;
            pc2_q        <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        pc1_q <= req_pc1_i;
                        pc2_q <= req_pc2_i;
                        state <= StLookup;
                    end
                end
                StLookup: begin
                    if (cancel_i) begin
                        state <= StIdle;
                    end else if (pc1_q[1:0] != 2'b00) begin
                        resp_q       <= pack_resp(1'b0, 32'd0, 1'b1, 32'd0);
                        resp_valid_q <= 1'b1;
                        state        <= StResp;
                    end else if (hit1) begin
                        resp_q       <= pack_resp(pair_ok, pair_ok ? data2 : 32'd0, 1'b1, data1);
                        resp_valid_q <= 1'b1;
                        state        <= StResp;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc1_q;
                        state      <= StMiss;
                    end
                end
                StMiss: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        if (cancel_i) begin
                            state <= StIdle;
                        end else begin
                            resp_q       <= pack_resp(1'b0, 32'd0, 1'b1, mem_rdata_i);
                            resp_valid_q <= 1'b1;
                            state        <= StResp;
                        end
                    end else if (cancel_i) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state     <= StIdle;
                    end
                end
                StResp: begin
                    if (cancel_i || resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        resp_q       <= '0;
                        if (accept) begin
                            pc1_q <= req_pc1_i;
                            pc2_q <= req_pc2_i;
                            state <= StLookup;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign resp_valid_o    = resp_valid_q;
    assign resp_inst1_o    = resp_q.inst1;
    assign resp_inst1_en_o = resp_q.inst1_en;
    assign resp_inst2_o    = resp_q.inst2;
    assign resp_inst2_en_o = resp_q.inst2_en;
    assign mem_req_o       = mem_req_q;
    assign mem_addr_o      = mem_addr_q;

endmodule

// File: tb/tb_icache_pair_resp.sv
// Directed bench for icache_pair_resp: cold miss/refill, paired hits, misaligned pc,
// cancel during miss, response back-pressure and flash invalidate.
module tb_icache_pair_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_pc1, req_pc2;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_inst1, resp_inst2;
    logic        resp_inst1_en, resp_inst2_en;
    logic        cancel, inv_all, wr_en;
    logic [31:0] wr_pc, wr_inst;
    logic        mem_req, mem_ack;
    logic [31:0] mem_addr, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int n_mem_req = 0;
    logic mem_req_prev = 1'b0;

    icache_pair_resp dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_pc1_i       (req_pc1),
        .req_pc2_i       (req_pc2),
        .resp_valid_o    (resp_valid),
        .resp_ready_i    (resp_ready),
        .resp_inst1_o    (resp_inst1),
        .resp_inst1_en_o (resp_inst1_en),
        .resp_inst2_o    (resp_inst2),
        .resp_inst2_en_o (resp_inst2_en),
        .cancel_i        (cancel),
        .inv_all_i       (inv_all),
        .wr_en_i         (wr_en),
        .wr_pc_i         (wr_pc),
        .wr_inst_i       (wr_inst),
        .mem_req_o       (mem_req),
        .mem_addr_o      (mem_addr),
        .mem_ack_i       (mem_ack),
        .mem_rdata_i     (mem_rdata)
    );

    always #5 clk = ~clk;

    // Count refill requests by their rising edge
    always @(negedge clk) begin
        if (mem_req && !mem_req_prev) n_mem_req++;
        mem_req_prev = mem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic issue(input logic [31:0] pc1, input logic [31:0] pc2);
        req_valid = 1'b1;
        req_pc1   = pc1;
        req_pc2   = pc2;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; req_valid = 0; req_pc1 = 0; req_pc2 = 0; resp_ready = 0;
        cancel = 0; inv_all = 0; wr_en = 0; wr_pc = 0; wr_inst = 0; mem_ack = 0; mem_rdata = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_inst1_en", {31'd0, resp_inst1_en}, 32'd0);
        chk("rst_inst2_en", {31'd0, resp_inst2_en}, 32'd0);
        chk("rst_inst1", resp_inst1, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Cold fetch: miss, refill after 3-cycle ack delay
        issue(32'h1C00_0000, 32'h1C00_0004);
        chk("cold_lookup_ready", {31'd0, req_ready}, 32'd0);
        tick();
        chk("cold_mem_req", {31'd0, mem_req}, 32'd1);
        chk("cold_mem_addr", mem_addr, 32'h1C00_0000);
        tick();
        tick();
        chk("cold_mem_req_held", {31'd0, mem_req}, 32'd1);
        chk("cold_no_resp", {31'd0, resp_valid}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0280_0421;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'd0;
        chk("cold_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("cold_inst1", resp_inst1, 32'h0280_0421);
        chk("cold_inst1_en", {31'd0, resp_inst1_en}, 32'd1);
        chk("cold_inst2_en", {31'd0, resp_inst2_en}, 32'd0);
        chk("cold_mem_req_done", {31'd0, mem_req}, 32'd0);
        chk("cold_one_req", n_mem_req, 32'd1);

        // Back-to-back refetch of the same pc hits
        resp_ready = 1'b1;
        issue(32'h1C00_0000, 32'h1C00_0004);
        resp_ready = 1'b0;
        chk("refetch_lookup_no_resp", {31'd0, resp_valid}, 32'd0);
        tick();
        chk("refetch_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("refetch_inst1", resp_inst1, 32'h0280_0421);
        chk("refetch_inst2_en", {31'd0, resp_inst2_en}, 32'd0);
        chk("refetch_no_mem_req", {31'd0, mem_req}, 32'd0);
        release_resp();
        chk("refetch_idle_ready", {31'd0, req_ready}, 32'd1);

        // Prefill both lanes, then a paired hit
        wr_en = 1'b1; wr_pc = 32'h1C00_0010; wr_inst = 32'hAAAA_0001;
        tick();
        wr_pc = 32'h1C00_0014; wr_inst = 32'hBBBB_0002;
        tick();
        wr_en = 1'b0;
        issue(32'h1C00_0010, 32'h1C00_0014);
        tick();
        chk("pair_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("pair_inst1", resp_inst1, 32'hAAAA_0001);
        chk("pair_inst1_en", {31'd0, resp_inst1_en}, 32'd1);
        chk("pair_inst2", resp_inst2, 32'hBBBB_0002);
        chk("pair_inst2_en", {31'd0, resp_inst2_en}, 32'd1);
        chk("pair_no_mem_req", {31'd0, mem_req}, 32'd0);
        release_resp();

        // Misaligned pc1
        issue(32'h1C00_0002, 32'h1C00_0006);
        tick();
        chk("mis_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("mis_inst1", resp_inst1, 32'd0);
        chk("mis_inst1_en", {31'd0, resp_inst1_en}, 32'd1);
        chk("mis_inst2_en", {31'd0, resp_inst2_en}, 32'd0);
        chk("mis_no_mem_req", {31'd0, mem_req}, 32'd0);
        release_resp();

        // Miss cancelled before ack: drain, fill, no response
        issue(32'h1C00_0120, 32'h1C00_0124);
        tick();
        chk("cxl_mem_req", {31'd0, mem_req}, 32'd1);
        chk("cxl_mem_addr", mem_addr, 32'h1C00_0120);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cxl_drain_mem_req", {31'd0, mem_req}, 32'd1);
        chk("cxl_drain_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("cxl_req_count", n_mem_req, 32'd2);
        tick();
        chk("cxl_drain_mem_req2", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'd0;
        chk("cxl_after_ack_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("cxl_after_ack_mem_req", {31'd0, mem_req}, 32'd0);
        chk("cxl_after_ack_ready", {31'd0, req_ready}, 32'd1);
        tick();
        chk("cxl_still_no_resp", {31'd0, resp_valid}, 32'd0);
        issue(32'h1C00_0120, 32'h1C00_0124);
        tick();
        chk("cxl_refetch_valid", {31'd0, resp_valid}, 32'd1);
        chk("cxl_refetch_inst1", resp_inst1, 32'h1234_5678);
        chk("cxl_refetch_no_req", n_mem_req, 32'd2);
        release_resp();

        // Back-pressure: 4 stalled cycles, then accept in the same cycle as ready
        issue(32'h1C00_0010, 32'h1C00_0014);
        tick();
        chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_hold_inst1", resp_inst1, 32'hAAAA_0001);
            chk("bp_hold_inst2", resp_inst2, 32'hBBBB_0002);
            chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1; req_valid = 1'b1;
        req_pc1 = 32'h1C00_0000; req_pc2 = 32'h1C00_0004;
        #1;
        chk("bp_ready_follows", {31'd0, req_ready}, 32'd1);
        tick();
        resp_ready = 1'b0; req_valid = 1'b0;
        chk("bp_accepted_lookup", {31'd0, resp_valid}, 32'd0);
        tick();
        chk("bp_new_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("bp_new_inst1", resp_inst1, 32'h0280_0421);
        release_resp();

        // Invalidate wins over a same-cycle fill to index 5
        inv_all = 1'b1; wr_en = 1'b1; wr_pc = 32'h1C00_0014; wr_inst = 32'hDEAD_BEEF;
        tick();
        inv_all = 1'b0; wr_en = 1'b0;
        issue(32'h1C00_0014, 32'h1C00_0018);
        tick();
        chk("inv_miss_mem_req", {31'd0, mem_req}, 32'd1);
        chk("inv_miss_addr", mem_addr, 32'h1C00_0014);
        chk("inv_no_resp", {31'd0, resp_valid}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'd0;
        chk("inv_refill_inst1", resp_inst1, 32'h0000_0055);
        chk("inv_refill_valid", {31'd0, resp_valid}, 32'd1);
        chk("inv_req_count", n_mem_req, 32'd3);
        release_resp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
